// File: rtl/textmode_pkg.sv
// rtl/textmode_pkg.sv - shared geometry, command codes and sequencer states for the text-mode writer
package textmode_pkg;

    localparam int         TM_COLS     = 80;
    localparam int         TM_ROWS     = 60;
    localparam int         TM_ROW_STEP = 2;
    localparam logic [6:0] TM_BLANK    = 7'h00;

    localparam logic [6:0] CHR_BS  = 7'h08;
    localparam logic [6:0] CHR_LF  = 7'h0A;
    localparam logic [6:0] CHR_CR  = 7'h0D;
    localparam logic [6:0] CHR_CLR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL,
        FILL
    } state_t;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/textmode_write_ctrl_walker.sv
// rtl/textmode_write_ctrl_walker.sv - raster address walker shared by the clear, scroll and fill engines
module fb_raster_walker
    import textmode_pkg::*;
#(
    parameter int COLS = TM_COLS,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = 6
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [YW-1:0] i_row_first,
    input  logic [YW-1:0] i_row_last,
    input  logic          i_step,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [YW-1:0] r_row_last;
    logic [XW-1:0] w_base_x;
    logic [YW-1:0] w_base_y;

    // start together with step consumes the first cell, which the caller issues itself
    always_comb begin
        w_base_x = i_start ? '0 : r_x;
        w_base_y = i_start ? i_row_first : r_y;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_last <= '0;
        end else begin
            if (i_start) begin
                r_row_last <= i_row_last;
            end
            if (i_step) begin
                if (w_base_x == XW'(COLS - 1)) begin
                    r_x <= '0;
                    r_y <= w_base_y + 1'b1;
                end else begin
                    r_x <= w_base_x + 1'b1;
                    r_y <= w_base_y;
                end
            end else if (i_start) begin
                r_x <= w_base_x;
                r_y <= w_base_y;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == XW'(COLS - 1)) && (r_y == r_row_last);

endmodule

// File: rtl/textmode_write_ctrl.sv
// rtl/textmode_write_ctrl.sv - command sequencer owning the cursor and all framebuffer write traffic
module textmode_write_ctrl
    import textmode_pkg::*;
#(
    parameter int         COLS     = TM_COLS,
    parameter int         ROWS     = TM_ROWS,
    parameter int         ROW_STEP = TM_ROW_STEP,
    parameter logic [6:0] BLANK    = TM_BLANK,
    parameter int         XW       = $clog2(COLS),
    parameter int         YW       = $clog2(ROWS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CMD_VALID,
    input  logic [6:0]    CMD_DATA,
    output logic          CMD_READY,
    output logic          FB_WE,
    output logic [XW-1:0] FB_WX,
    output logic [YW-1:0] FB_WY,
    output logic [6:0]    FB_WDATA,
    output logic [XW-1:0] FB_RX,
    output logic [YW-1:0] FB_RY,
    input  logic [6:0]    FB_RDATA,
    output logic          BUSY,
    output logic [XW-1:0] CURSOR_X,
    output logic [YW-1:0] CURSOR_Y
);

    state_t        r_state, w_state_n;
    logic [XW-1:0] r_cx, w_cx_n;
    logic [YW-1:0] r_cy, w_cy_n;
    logic          r_fb_we, w_fb_we_n;
    logic [XW-1:0] r_fb_wx, w_fb_wx_n;
    logic [YW-1:0] r_fb_wy, w_fb_wy_n;
    logic [6:0]    r_fb_wdata, w_fb_wdata_n;
    logic [XW-1:0] r_fb_rx, w_fb_rx_n;
    logic [YW-1:0] r_fb_ry, w_fb_ry_n;
    logic          r_copy, w_copy_n;
    logic          r_rd_valid, w_rd_valid_n;
    logic          r_tail, w_tail_n;

    logic          w_accept;
    logic          w_lf;
    logic [YW:0]   w_y_ext;
    logic          w_lf_fits;
    logic          w_walk_start, w_walk_step;
    logic [YW-1:0] w_walk_first, w_walk_row_last;
    logic [XW-1:0] w_walk_x;
    logic [YW-1:0] w_walk_y;
    logic          w_walk_last;

    fb_raster_walker #(
        .COLS (COLS),
        .XW   (XW),
        .YW   (YW)
    ) u_walker (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_start     (w_walk_start),
        .i_row_first (w_walk_first),
        .i_row_last  (w_walk_row_last),
        .i_step      (w_walk_step),
        .o_x         (w_walk_x),
        .o_y         (w_walk_y),
        .o_last      (w_walk_last)
    );

    assign CMD_READY = (r_state == IDLE) && !RESET;
    assign w_accept  = CMD_VALID && CMD_READY;
    assign w_y_ext   = {1'b0, r_cy} + (YW + 1)'(ROW_STEP);
    assign w_lf_fits = w_y_ext <= (YW + 1)'(ROWS - 1);

    always_comb begin
        w_state_n       = r_state;
        w_cx_n          = r_cx;
        w_cy_n          = r_cy;
        w_fb_we_n       = 1'b0;
        w_fb_wx_n       = r_fb_wx;
        w_fb_wy_n       = r_fb_wy;
        w_fb_wdata_n    = r_fb_wdata;
        w_fb_rx_n       = r_fb_rx;
        w_fb_ry_n       = r_fb_ry;
        w_copy_n        = 1'b0;
        w_rd_valid_n    = 1'b0;
        w_tail_n        = r_tail;
        w_lf            = 1'b0;
        w_walk_start    = 1'b0;
        w_walk_step     = 1'b0;
        w_walk_first    = '0;
        w_walk_row_last = YW'(ROWS - 1);

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tail_n = 1'b0;
                    if (is_printable(CMD_DATA)) begin
                        w_fb_we_n    = 1'b1;
                        w_fb_wx_n    = r_cx;
                        w_fb_wy_n    = r_cy;
                        w_fb_wdata_n = CMD_DATA;
                        if (r_cx == XW'(COLS - 1)) begin
                            w_cx_n = '0;
                            w_lf   = 1'b1;
                        end else begin
                            w_cx_n = r_cx + 1'b1;
                        end
                    end else begin
                        case (CMD_DATA)
                            CHR_CR: w_cx_n = '0;
                            CHR_LF: w_lf = 1'b1;
                            CHR_BS: begin
                                if (r_cx != '0) begin
                                    w_cx_n       = r_cx - 1'b1;
                                    w_fb_we_n    = 1'b1;
                                    w_fb_wx_n    = r_cx - 1'b1;
                                    w_fb_wy_n    = r_cy;
                                    w_fb_wdata_n = BLANK;
                                end
                            end
                            CHR_CLR: begin
                                w_state_n    = CLEAR;
                                w_fb_we_n    = 1'b1;
                                w_fb_wx_n    = '0;
                                w_fb_wy_n    = '0;
                                w_fb_wdata_n = BLANK;
                                w_walk_start = 1'b1;
                                w_walk_step  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (w_lf) begin
                        if (w_lf_fits) begin
                            w_cy_n = w_y_ext[YW-1:0];
                        end else begin
                            w_state_n    = SCROLL;
                            w_fb_rx_n    = '0;
                            w_fb_ry_n    = YW'(ROW_STEP);
                            w_rd_valid_n = 1'b1;
                            w_walk_start = 1'b1;
                            w_walk_step  = 1'b1;
                            w_walk_first = YW'(ROW_STEP);
                        end
                    end
                end
            end
            CLEAR: begin
                if (r_tail) begin
                    w_state_n = IDLE;
                    w_tail_n  = 1'b0;
                    w_cx_n    = '0;
                    w_cy_n    = '0;
                end else begin
                    w_fb_we_n    = 1'b1;
                    w_fb_wx_n    = w_walk_x;
                    w_fb_wy_n    = w_walk_y;
                    w_fb_wdata_n = BLANK;
                    w_walk_step  = 1'b1;
                    w_tail_n     = w_walk_last;
                end
            end
            SCROLL: begin
                // each copy write retires the read issued one cycle earlier
                w_fb_we_n = r_rd_valid;
                w_copy_n  = r_rd_valid;
                w_fb_wx_n = r_fb_rx;
                w_fb_wy_n = r_fb_ry - YW'(ROW_STEP);
                if (r_tail) begin
                    w_state_n    = FILL;
                    w_tail_n     = 1'b0;
                    w_walk_start = 1'b1;
                    w_walk_first = YW'(ROWS - ROW_STEP);
                end else begin
                    w_fb_rx_n    = w_walk_x;
                    w_fb_ry_n    = w_walk_y;
                    w_rd_valid_n = 1'b1;
                    w_walk_step  = 1'b1;
                    w_tail_n     = w_walk_last;
                end
            end
            FILL: begin
                if (r_tail) begin
                    w_state_n = IDLE;
                    w_tail_n  = 1'b0;
                end else begin
                    w_fb_we_n    = 1'b1;
                    w_fb_wx_n    = w_walk_x;
                    w_fb_wy_n    = w_walk_y;
                    w_fb_wdata_n = BLANK;
                    w_walk_step  = 1'b1;
                    w_tail_n     = w_walk_last;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_cx       <= '0;
            r_cy       <= '0;
            r_fb_we    <= 1'b0;
            r_fb_wx    <= '0;
            r_fb_wy    <= '0;
            r_fb_wdata <= '0;
            r_fb_rx    <= '0;
            r_fb_ry    <= '0;
            r_copy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cx       <= w_cx_n;
            r_cy       <= w_cy_n;
            r_fb_we    <= w_fb_we_n;
            r_fb_wx    <= w_fb_wx_n;
            r_fb_wy    <= w_fb_wy_n;
            r_fb_wdata <= w_fb_wdata_n;
            r_fb_rx    <= w_fb_rx_n;
            r_fb_ry    <= w_fb_ry_n;
            r_copy     <= w_copy_n;
            r_rd_valid <= w_rd_valid_n;
            r_tail     <= w_tail_n;
        end
    end

    // copy writes forward the RAM read data so the write trails its read by one cycle
    assign FB_WE    = r_fb_we;
    assign FB_WX    = r_fb_wx;
    assign FB_WY    = r_fb_wy;
    assign FB_WDATA = r_copy ? FB_RDATA : r_fb_wdata;
    assign FB_RX    = r_fb_rx;
    assign FB_RY    = r_fb_ry;
    assign BUSY     = (r_state != IDLE);
    assign CURSOR_X = r_cx;
    assign CURSOR_Y = r_cy;

endmodule

// File: tb/tb_textmode_write_ctrl.sv
// tb/tb_textmode_write_ctrl.sv - self-checking bench for textmode_write_ctrl
module tb_textmode_write_ctrl;

    logic       CLK;
    logic       RESET;
    logic       CMD_VALID;
    logic [6:0] CMD_DATA;
    logic       CMD_READY;
    logic       FB_WE;
    logic [6:0] FB_WX;
    logic [5:0] FB_WY;
    logic [6:0] FB_WDATA;
    logic [6:0] FB_RX;
    logic [5:0] FB_RY;
    logic [6:0] FB_RDATA;
    logic       BUSY;
    logic [6:0] CURSOR_X;
    logic [5:0] CURSOR_Y;

    textmode_write_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_DATA  (CMD_DATA),
        .CMD_READY (CMD_READY),
        .FB_WE     (FB_WE),
        .FB_WX     (FB_WX),
        .FB_WY     (FB_WY),
        .FB_WDATA  (FB_WDATA),
        .FB_RX     (FB_RX),
        .FB_RY     (FB_RY),
        .FB_RDATA  (FB_RDATA),
        .BUSY      (BUSY),
        .CURSOR_X  (CURSOR_X),
        .CURSOR_Y  (CURSOR_Y)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] pat(input int x, input int y);
        return 7'((x * 5 + y * 11 + 3) % 128);
    endfunction

    // framebuffer model: synchronous read, write commits on the edge ending the strobe cycle
    logic [6:0] mem [0:63][0:127];
    logic [6:0] g   [0:63][0:127];
    logic       preload_req;

    always @(posedge CLK) begin
        if (preload_req) begin
            for (int y = 0; y < 64; y++)
                for (int x = 0; x < 128; x++)
                    mem[y][x] <= pat(x, y);
        end else if (FB_WE) begin
            mem[FB_WY][FB_WX] <= FB_WDATA;
        end
        FB_RDATA <= mem[FB_RY][FB_RX];
    end

    int sb[$];

    task automatic push_write(input int x, input int y, input logic [6:0] d);
        sb.push_back((x << 13) | (y << 7) | int'(d));
        g[y][x] = d;
    endtask

    always @(negedge CLK) begin
        if (FB_WE) begin
            if (sb.size() == 0) check("sb_unexpected_we", int'(FB_WE), 0);
            else check("sb_write", int'({FB_WX, FB_WY, FB_WDATA}), sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        bit         valid;
        logic [6:0] data;
        bit         we;
        int         wx;
        int         wy;
        logic [6:0] wd;
        int         cx;
        int         cy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit v, input logic [6:0] d, input bit we, input int wx, input int wy,
                       input logic [6:0] wd, input int cx, input int cy);
        vec_t t;
        t.valid = v; t.data = d; t.we = we; t.wx = wx; t.wy = wy; t.wd = wd; t.cx = cx; t.cy = cy;
        vecs.push_back(t);
    endtask

    int n;
    int nwe;
    int mism;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; CMD_VALID = 1'b0; CMD_DATA = 7'h00; preload_req = 1'b0;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 128; x++)
                g[y][x] = 7'h00;

        repeat (3) tick();
        check("rst_ready", int'(CMD_READY), 0);
        check("rst_we", int'(FB_WE), 0);
        check("rst_wx", int'(FB_WX), 0);
        check("rst_wy", int'(FB_WY), 0);
        check("rst_wdata", int'(FB_WDATA), 0);
        check("rst_rx", int'(FB_RX), 0);
        check("rst_ry", int'(FB_RY), 0);
        check("rst_cx", int'(CURSOR_X), 0);
        check("rst_cy", int'(CURSOR_Y), 0);
        check("rst_busy", int'(BUSY), 0);
        RESET = 1'b0;
        #1;
        check("ready_after_rst", int'(CMD_READY), 1);

        add(1, 7'h41, 1, 0, 4 - 4, 7'h41, 1, 0);
        add(1, 7'h0D, 0, 0, 0, 7'h00, 0, 0);
        add(1, 7'h08, 0, 0, 0, 7'h00, 0, 0);
        add(1, 7'h0A, 0, 0, 0, 7'h00, 0, 2);
        add(1, 7'h0A, 0, 0, 0, 7'h00, 0, 4);
        add(1, 7'h78, 1, 0, 4, 7'h78, 1, 4);
        add(1, 7'h79, 1, 1, 4, 7'h79, 2, 4);
        add(1, 7'h7A, 1, 2, 4, 7'h7A, 3, 4);
        add(1, 7'h08, 1, 2, 4, 7'h00, 2, 4);
        add(1, 7'h01, 0, 0, 0, 7'h00, 2, 4);
        add(1, 7'h1F, 0, 0, 0, 7'h00, 2, 4);
        add(1, 7'h7E, 1, 2, 4, 7'h7E, 3, 4);
        add(1, 7'h20, 1, 3, 4, 7'h20, 4, 4);
        add(0, 7'h41, 0, 0, 0, 7'h00, 4, 4);
        add(1, 7'h0D, 0, 0, 0, 7'h00, 0, 4);
        add(1, 7'h0A, 0, 0, 0, 7'h00, 0, 6);
        for (int i = 0; i < 5; i++)
            add(1, 7'(7'h61 + i), 1, i, 6, 7'(7'h61 + i), i + 1, 6);

        foreach (vecs[i]) begin
            CMD_VALID = vecs[i].valid;
            CMD_DATA  = vecs[i].data;
            if (vecs[i].valid && vecs[i].we) push_write(vecs[i].wx, vecs[i].wy, vecs[i].wd);
            tick();
            check("vec_ready", int'(CMD_READY), 1);
            check("vec_we", int'(FB_WE), int'(vecs[i].we));
            check("vec_cx", int'(CURSOR_X), vecs[i].cx);
            check("vec_cy", int'(CURSOR_Y), vecs[i].cy);
        end
        CMD_VALID = 1'b0;

        // clear from (5,6)
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++)
                push_write(x, y, 7'h00);
        CMD_VALID = 1'b1; CMD_DATA = 7'h7F;
        tick();
        CMD_VALID = 1'b0;
        n = 0; nwe = 0;
        while (!CMD_READY && n < 6000) begin
            n++;
            if (FB_WE) nwe++;
            tick();
        end
        check("clr_ready_low_cycles", n, 4800);
        check("clr_we_cycles", nwe, 4800);
        check("clr_we_after", int'(FB_WE), 0);
        check("clr_busy_after", int'(BUSY), 0);
        check("clr_cx", int'(CURSOR_X), 0);
        check("clr_cy", int'(CURSOR_Y), 0);

        // 80 printable characters wrap onto the next double-spaced row
        for (int i = 0; i < 80; i++) begin
            CMD_VALID = 1'b1; CMD_DATA = 7'(7'h21 + i);
            push_write(i, 0, 7'(7'h21 + i));
            tick();
            check("row_we", int'(FB_WE), 1);
            check("row_cx", int'(CURSOR_X), (i == 79) ? 0 : i + 1);
            check("row_cy", int'(CURSOR_Y), (i == 79) ? 2 : 0);
        end
        for (int i = 0; i < 28; i++) begin
            CMD_DATA = 7'h0A;
            tick();
        end
        CMD_VALID = 1'b0;
        check("lf_cy58", int'(CURSOR_Y), 58);

        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 128; x++)
                g[y][x] = pat(x, y);

        // line feed at the bottom: scroll then fill
        for (int y = 0; y < 58; y++)
            for (int x = 0; x < 80; x++)
                push_write(x, y, g[y + 2][x]);
        for (int y = 58; y < 60; y++)
            for (int x = 0; x < 80; x++)
                push_write(x, y, 7'h00);
        CMD_VALID = 1'b1; CMD_DATA = 7'h0A;
        tick();
        CMD_VALID = 1'b0;
        check("scr_bubble_we", int'(FB_WE), 0);
        n = 0;
        while (BUSY && n < 6000) begin
            n++;
            tick();
        end
        check("scr_busy_cycles", n, 4801);
        check("scr_cx", int'(CURSOR_X), 0);
        check("scr_cy", int'(CURSOR_Y), 58);
        check("scr_ready", int'(CMD_READY), 1);

        // row of characters whose wrap triggers the scroll
        for (int i = 0; i < 80; i++) begin
            CMD_VALID = 1'b1; CMD_DATA = 7'(7'h30 + (i % 40));
            push_write(i, 58, 7'(7'h30 + (i % 40)));
            if (i == 79) begin
                for (int y = 0; y < 58; y++)
                    for (int x = 0; x < 80; x++)
                        push_write(x, y, g[y + 2][x]);
                for (int y = 58; y < 60; y++)
                    for (int x = 0; x < 80; x++)
                        push_write(x, y, 7'h00);
            end
            tick();
            if (i < 79) check("wrap_cx", int'(CURSOR_X), i + 1);
        end
        CMD_VALID = 1'b0;
        check("wrap_char_we", int'(FB_WE), 1);
        check("wrap_busy", int'(BUSY), 1);
        check("wrap_cx0", int'(CURSOR_X), 0);
        n = 0;
        while (BUSY && n < 6000) begin
            n++;
            tick();
        end
        check("wrap_busy_cycles", n, 4801);
        check("wrap_cy", int'(CURSOR_Y), 58);

        // reset 100 cycles into a clear
        for (int i = 0; i < 100; i++)
            push_write(i % 80, i / 80, 7'h00);
        CMD_VALID = 1'b1; CMD_DATA = 7'h7F;
        tick();
        CMD_VALID = 1'b0;
        repeat (99) tick();
        check("mid_clr_we", int'(FB_WE), 1);
        RESET = 1'b1;
        tick();
        check("rst_mid_we", int'(FB_WE), 0);
        check("rst_mid_cx", int'(CURSOR_X), 0);
        check("rst_mid_cy", int'(CURSOR_Y), 0);
        check("rst_mid_busy", int'(BUSY), 0);
        check("rst_mid_ready", int'(CMD_READY), 0);
        RESET = 1'b0;
        #1;
        check("rst_mid_ready_after", int'(CMD_READY), 1);

        repeat (3) tick();
        check("sb_drained", sb.size(), 0);
        mism = 0;
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++)
                if (mem[y][x] !== g[y][x]) mism++;
        check("ram_image_mismatches", mism, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
